// File: rtl/ide_pio_sequencer_if.sv
// Bus-side and drive-side signals of the IDE PIO sequencer.
// The slave modport is the sequencer; the master modport is whatever drives the 68000 bus.
interface ide_pio_sequencer_if;
    logic       AS_n;
    logic       UDS_n;
    logic       LDS_n;
    logic       RW;
    logic [4:0] ADDR;
    logic       ide_access;
    logic       ide_enable;
    logic       IORDY;
    logic       dtack;
    logic       IOR_n;
    logic       IOW_n;
    logic       IDECS1_n;
    logic       IDECS2_n;
    logic       IDE_ROMEN;
    logic       busy;
    logic       timeout;

    modport master (
        output AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, ide_enable, IORDY,
        input  dtack, IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDE_ROMEN, busy, timeout
    );

    modport slave (
        input  AS_n, UDS_n, LDS_n, RW, ADDR, ide_access, ide_enable, IORDY,
        output dtack, IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDE_ROMEN, busy, timeout
    );
endinterface

// File: rtl/ide_pio_sequencer.sv
// Per-access IDE PIO timing engine: turns a decoded board-space cycle into chip-selects,
// IOR_n/IOW_n strobes, a bounded IORDY wait, boot-ROM enable and a DTACK request.
module ide_pio_sequencer #(
    parameter int T_SETUP  = 2,
    parameter int T_ACTIVE = 3,
    parameter int T_HOLD   = 1,
    parameter int T_ROM    = 2,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 7
) (
    input logic                CLK,
    input logic                RESET_n,
    ide_pio_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, ROM, ACK_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETUP_CNT   = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] ACTIVE_CNT  = CNT_W'(T_ACTIVE);
    localparam logic [CNT_W-1:0] HOLD_CNT    = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] ROM_CNT     = CNT_W'(T_ROM);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rw_q;
    logic             dtack_q;
    logic             ior_n_q;
    logic             iow_n_q;
    logic             cs1_n_q;
    logic             cs2_n_q;
    logic             romen_q;
    logic             busy_q;
    logic             timeout_q;

    logic             start;
    logic             abort;
    logic             timed_out;
    logic [CNT_W-1:0] cnt_inc;
    logic             unused_addr;

    assign start     = bus.ide_access & ~bus.AS_n & (~bus.UDS_n | ~bus.LDS_n);
    // ACK_WAIT's normal exit and a mid-access abort look identical: AS_n high releases everything.
    assign abort     = bus.AS_n & (state != IDLE);
    assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_ONE;
    assign timed_out = (state == ACTIVE) & (cnt >= TIMEOUT_CNT) & ~bus.IORDY;
    // Only A16 (ROM window) and A12 (CS1/CS2) steer the access.
    assign unused_addr = ^bus.ADDR[3:1];

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rw_q      <= 1'b1;
            dtack_q   <= 1'b0;
            ior_n_q   <= 1'b1;
            iow_n_q   <= 1'b1;
            cs1_n_q   <= 1'b1;
            cs2_n_q   <= 1'b1;
            romen_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            if (timed_out) begin
                timeout_q <= 1'b1;
            end
            if (abort) begin
                state   <= IDLE;
                cnt     <= CNT_ONE;
                dtack_q <= 1'b0;
                ior_n_q <= 1'b1;
                iow_n_q <= 1'b1;
                cs1_n_q <= 1'b1;
                cs2_n_q <= 1'b1;
                romen_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            rw_q   <= bus.RW;
                            cnt    <= CNT_ONE;
                            busy_q <= 1'b1;
                            if (bus.ADDR[4]) begin
                                state   <= ROM;
                                romen_q <= 1'b1;
                            end else if (!bus.ide_enable) begin
                                // No drives fitted: acknowledge at once so the CPU never hangs.
                                state   <= ACK_WAIT;
                                dtack_q <= 1'b1;
                            end else begin
                                state   <= SETUP;
                                cs1_n_q <= bus.ADDR[0];
                                cs2_n_q <= ~bus.ADDR[0];
                            end
                        end
                    end
                    SETUP: begin
                        if (cnt >= SETUP_CNT) begin
                            state   <= ACTIVE;
                            cnt     <= CNT_ONE;
                            ior_n_q <= ~rw_q;
                            iow_n_q <= rw_q;
                        end
                    end
                    ACTIVE: begin
                        // IORDY is only honoured once the minimum strobe width has elapsed.
                        if (((cnt >= ACTIVE_CNT) && bus.IORDY) || (cnt >= TIMEOUT_CNT)) begin
                            state   <= HOLD;
                            cnt     <= CNT_ONE;
                            ior_n_q <= 1'b1;
                            iow_n_q <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt >= HOLD_CNT) begin
                            state   <= ACK_WAIT;
                            cnt     <= CNT_ONE;
                            dtack_q <= 1'b1;
                            cs1_n_q <= 1'b1;
                            cs2_n_q <= 1'b1;
                        end
                    end
                    ROM: begin
                        if (cnt >= ROM_CNT) begin
                            state   <= ACK_WAIT;
                            cnt     <= CNT_ONE;
                            dtack_q <= 1'b1;
                        end
                    end
                    ACK_WAIT: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.dtack     = dtack_q;
    assign bus.IOR_n     = ior_n_q;
    assign bus.IOW_n     = iow_n_q;
    assign bus.IDECS1_n  = cs1_n_q;
    assign bus.IDECS2_n  = cs2_n_q;
    assign bus.IDE_ROMEN = romen_q;
    assign bus.busy      = busy_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for ide_pio_sequencer: latency, strobe widths, IORDY stretch/timeout,
// ROM window, disabled drives, abort and asynchronous reset.
module tb_ide_pio_sequencer;
    logic CLK = 1'b0;
    logic RESET_n;

    int n_checks = 0;
    int n_pass   = 0;

    int   cs_at;
    int   str_at;
    int   str_len;
    int   dt_at;
    int   bad;
    logic cs1_seen;
    logic cs2_seen;
    logic ior_seen;
    logic iow_seen;
    logic romen_seen;

    // {dtack, IOR_n, IOW_n, IDECS1_n, IDECS2_n, IDE_ROMEN, busy, timeout}
    localparam logic [7:0] IDLE_OUTS    = 8'b0111_1000;
    localparam logic [7:0] IDLE_OUTS_TO = 8'b0111_1001;

    ide_pio_sequencer_if bus_if ();

    ide_pio_sequencer dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus_if)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    function automatic logic [31:0] outs();
        return {24'd0, bus_if.dtack, bus_if.IOR_n, bus_if.IOW_n, bus_if.IDECS1_n,
                bus_if.IDECS2_n, bus_if.IDE_ROMEN, bus_if.busy, bus_if.timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic begin_access(input logic [4:0] addr, input logic rw);
        bus_if.ADDR       = addr;
        bus_if.RW         = rw;
        bus_if.AS_n       = 1'b0;
        bus_if.UDS_n      = 1'b0;
        bus_if.LDS_n      = 1'b1;
        bus_if.ide_access = 1'b1;
    endtask

    task automatic end_access();
        bus_if.AS_n       = 1'b1;
        bus_if.UDS_n      = 1'b1;
        bus_if.LDS_n      = 1'b1;
        bus_if.ide_access = 1'b0;
    endtask

    // Steps from the start edge (k=0) until dtack or max_cyc edges; optionally raises IORDY after edge iordy_rel.
    task automatic measure(input int max_cyc, input int iordy_rel);
        cs_at = -1; str_at = -1; str_len = 0; dt_at = -1; bad = 0;
        cs1_seen = 0; cs2_seen = 0; ior_seen = 0; iow_seen = 0; romen_seen = 0;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (!bus_if.IDECS1_n) cs1_seen = 1'b1;
            if (!bus_if.IDECS2_n) cs2_seen = 1'b1;
            if (!bus_if.IOR_n)    ior_seen = 1'b1;
            if (!bus_if.IOW_n)    iow_seen = 1'b1;
            if (bus_if.IDE_ROMEN) romen_seen = 1'b1;
            if (cs_at < 0 && (!bus_if.IDECS1_n || !bus_if.IDECS2_n)) cs_at = k;
            if (!bus_if.IOR_n || !bus_if.IOW_n) begin
                if (str_at < 0) str_at = k;
                str_len++;
                if (!bus_if.IOR_n && !bus_if.IOW_n) bad++;
                if (bus_if.IDECS1_n == bus_if.IDECS2_n) bad++;
            end
            if (k == iordy_rel) bus_if.IORDY = 1'b1;
            if (bus_if.dtack) begin
                dt_at = k;
                break;
            end
        end
    endtask

    initial begin
        RESET_n           = 1'b1;
        bus_if.AS_n       = 1'b1;
        bus_if.UDS_n      = 1'b1;
        bus_if.LDS_n      = 1'b1;
        bus_if.RW         = 1'b1;
        bus_if.ADDR       = 5'h00;
        bus_if.ide_access = 1'b0;
        bus_if.ide_enable = 1'b1;
        bus_if.IORDY      = 1'b1;

        #2 RESET_n = 1'b0;
        #1 check("reset_async", outs(), {24'd0, IDLE_OUTS});
        step();
        check("reset_clocked", outs(), {24'd0, IDLE_OUTS});
        RESET_n = 1'b1;
        step();
        step();

        // No start without a data strobe, nor without a board-space hit
        bus_if.AS_n = 1'b0;
        bus_if.ide_access = 1'b1;
        step();
        check("no_ds_start", bus_if.busy, 0);
        bus_if.UDS_n = 1'b0;
        bus_if.ide_access = 1'b0;
        step();
        check("no_hit_start", bus_if.busy, 0);
        end_access();
        step();

        // Read, CS1
        begin_access(5'h00, 1'b1);
        measure(20, -1);
        check("rd_cs_at", cs_at, 0);
        check("rd_strobe_at", str_at, 2);
        check("rd_strobe_len", str_len, 3);
        check("rd_dtack_at", dt_at, 6);
        check("rd_sel", {cs1_seen, cs2_seen, ior_seen, iow_seen, romen_seen}, 5'b10100);
        check("rd_excl", bad, 0);
        check("rd_ackwait", outs(), 32'h0000_00FA);
        end_access();
        step();
        check("rd_idle", outs(), {24'd0, IDLE_OUTS});

        // Write, CS2
        begin_access(5'h01, 1'b0);
        measure(20, -1);
        check("wr_cs_at", cs_at, 0);
        check("wr_strobe_at", str_at, 2);
        check("wr_strobe_len", str_len, 3);
        check("wr_dtack_at", dt_at, 6);
        check("wr_sel", {cs1_seen, cs2_seen, ior_seen, iow_seen, romen_seen}, 5'b01010);
        check("wr_excl", bad, 0);
        end_access();
        step();
        check("wr_idle", outs(), {24'd0, IDLE_OUTS});

        // IORDY low for 10 clk beyond the minimum strobe width
        bus_if.IORDY = 1'b0;
        begin_access(5'h00, 1'b1);
        measure(40, 14);
        check("st_strobe_len", str_len, 13);
        check("st_dtack_at", dt_at, 16);
        check("st_timeout", bus_if.timeout, 0);
        end_access();
        step();

        // IORDY stuck low
        bus_if.IORDY = 1'b0;
        begin_access(5'h00, 1'b1);
        measure(100, -1);
        check("to_strobe_at", str_at, 2);
        check("to_strobe_len", str_len, 64);
        check("to_dtack_at", dt_at, 67);
        check("to_flag", bus_if.timeout, 1);
        end_access();
        step();
        check("to_idle", outs(), {24'd0, IDLE_OUTS_TO});
        bus_if.IORDY = 1'b1;

        // A good access afterwards leaves the sticky flag set
        begin_access(5'h00, 1'b1);
        measure(20, -1);
        check("post_to_dtack_at", dt_at, 6);
        check("post_to_flag", bus_if.timeout, 1);
        end_access();
        step();

        // Boot-ROM window
        begin_access(5'h10, 1'b1);
        measure(10, -1);
        check("rom_dtack_at", dt_at, 2);
        check("rom_sel", {cs1_seen, cs2_seen, ior_seen, iow_seen, romen_seen}, 5'b00001);
        check("rom_ackwait", outs(), 32'h0000_00FF);
        end_access();
        step();
        check("rom_idle", outs(), {24'd0, IDLE_OUTS_TO});

        // Drives disabled
        bus_if.ide_enable = 1'b0;
        begin_access(5'h00, 1'b1);
        measure(5, -1);
        check("dis_dtack_at", dt_at, 0);
        check("dis_sel", {cs1_seen, cs2_seen, ior_seen, iow_seen, romen_seen}, 5'b00000);
        end_access();
        step();
        bus_if.ide_enable = 1'b1;

        // Abort mid-ACTIVE, then an immediate new access
        begin_access(5'h00, 1'b1);
        step();
        step();
        step();
        step();
        check("ab_active", {bus_if.IOR_n, bus_if.IDECS1_n}, 2'b00);
        end_access();
        step();
        check("ab_released", outs(), {24'd0, IDLE_OUTS_TO});
        begin_access(5'h00, 1'b1);
        step();
        check("b2b_start", {bus_if.IDECS1_n, bus_if.busy}, 2'b01);

        // Reset mid-SETUP, checked between clock edges
        step();
        #3 RESET_n = 1'b0;
        #1 check("rst_setup", outs(), {24'd0, IDLE_OUTS});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
